spi_slave_regs: RTL and testbench

SPI responder for the team's `SPI` master: a 64 × 8 register bank reachable over the same four-wire bus (`spi_clk`, `spi_cs`, `spi_mosi`, `spi_miso`) using the master's 16-bit frame of R/W bit, MB bit, 6-bit address and 8-bit data. All bus pins are oversampled in the system `clk` domain. A local port lets on-chip logic load status registers, and a strobe reports each completed bus write. The block serves as the bus-side model and loopback target in master benches and as a configuration-register slave in the FPGA design.

---
 rtl/spi_slave_regs_pkg.sv | 19 +
 rtl/spi_slave_regs_sync.sv | 50 +++++
 rtl/spi_slave_regs.sv | 204 ++++++++++++++++++++
 tb/tb_spi_slave_regs.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/spi_slave_regs_pkg.sv
// spi_slave_pkg: shared constants and types for the SPI register slave.
//   ADDR_W / DATA_W : frame address and data widths
//   RW_BIT / MB_BIT : frame bit positions of the read/write and multibyte flags
//   RW_READ         : value of the R/W bit that requests a read
//   state_e         : frame FSM states
package spi_slave_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int RW_BIT = 15;
  localparam int MB_BIT = 14;
  localparam logic RW_READ = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/spi_slave_regs_sync.sv
// spi_slave_sync: brings the SPI pins into the clk domain and derives events.
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   spi_clk_i/cs_i/mosi_i raw bus pins
//   mosi_o             synchronized MOSI
//   sclk_rise_o/fall_o one-cycle pulses on synchronized spi_clk edges
//   cs_start_o/stop_o  one-cycle pulses on synchronized cs fall / rise
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_clk_i,
  input  logic spi_cs_i,
  input  logic spi_mosi_i,
  output logic mosi_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_start_o,
  output logic cs_stop_o
);
  logic [SYNC_STAGES-1:0] clk_sr_q, cs_sr_q, mosi_sr_q;
  logic clk_prev_q, cs_prev_q;
  logic clk_s, cs_s;

  // Chains reset to the bus idle levels so no edge is seen leaving reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sr_q   <= '1;
      cs_sr_q    <= '1;
      mosi_sr_q  <= '0;
      clk_prev_q <= 1'b1;
      cs_prev_q  <= 1'b1;
    end else begin
      clk_sr_q   <= {clk_sr_q[SYNC_STAGES-2:0], spi_clk_i};
      cs_sr_q    <= {cs_sr_q[SYNC_STAGES-2:0], spi_cs_i};
      mosi_sr_q  <= {mosi_sr_q[SYNC_STAGES-2:0], spi_mosi_i};
      clk_prev_q <= clk_s;
      cs_prev_q  <= cs_s;
    end
  end

  assign clk_s       = clk_sr_q[SYNC_STAGES-1];
  assign cs_s        = cs_sr_q[SYNC_STAGES-1];
  assign mosi_o      = mosi_sr_q[SYNC_STAGES-1];
  assign sclk_rise_o =  clk_s & ~clk_prev_q;
  assign sclk_fall_o = ~clk_s &  clk_prev_q;
  assign cs_start_o  = ~cs_s  &  cs_prev_q;
  assign cs_stop_o   =  cs_s  & ~cs_prev_q;
endmodule

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: 64x8 register bank behind a CPOL=1/CPHA=1 SPI slave.
// Frame: [15] R/W (1=read), [14] MB, [13:8] address, [7:0] data, MSB first.
// Ports:
//   clk, rst_n                 system clock, async active-low reset
//   spi_clk/cs/mosi            bus inputs (oversampled in clk)
//   spi_miso, spi_miso_oe      serial read data and its pad enable
//   busy                       frame in progress
//   loc_we/addr/wdata          local register load (bus commit wins on clash)
//   wr_valid/addr/data         one-cycle report of each committed bus write
// Build option: SPI_SLAVE_MULTIBYTE_EN lets MB=1 frames stream consecutive
// bytes with an auto-incrementing address; without it MB is ignored.
module spi_slave_regs
  import spi_slave_pkg::*;
#(
  parameter int NUM_REGS    = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              busy,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);
`ifdef SPI_SLAVE_MULTIBYTE_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  logic mosi_s, sclk_rise, sclk_fall, cs_start, cs_stop;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_clk_i  (spi_clk),
    .spi_cs_i   (spi_cs),
    .spi_mosi_i (spi_mosi),
    .mosi_o     (mosi_s),
    .sclk_rise_o(sclk_rise),
    .sclk_fall_o(sclk_fall),
    .cs_start_o (cs_start),
    .cs_stop_o  (cs_stop)
  );

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  logic [DATA_W-1:0] bank_q [NUM_REGS];

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-2:0] sh_in_q, sh_in_d;
  logic [DATA_W-1:0] sh_out_q, sh_out_d;
  logic              rw_q, rw_d, mb_q, mb_d, miso_q, miso_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  // Byte as it stands once the current MOSI bit is shifted in.
  logic [DATA_W-1:0] cur_byte;
  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] rd_cmd, rd_next;

  assign cur_byte = {sh_in_q, mosi_s};
  assign addr_inc = addr_q + 1'b1;
  assign rd_cmd   = in_range(cur_byte[ADDR_W-1:0]) ? bank_q[cur_byte[ADDR_W-1:0]] : '0;
  assign rd_next  = in_range(addr_inc) ? bank_q[addr_inc] : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_in_d     = sh_in_q;
    sh_out_d    = sh_out_q;
    rw_d        = rw_q;
    mb_d        = mb_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    pend_d      = 1'b0;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_start) begin
          state_d = CMD;
          cnt_d   = '0;
        end
      end
      CMD: begin
        miso_d = 1'b0;
        if (sclk_rise) begin
          sh_in_d = cur_byte[DATA_W-2:0];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 3'd7) begin
            rw_d    = cur_byte[RW_BIT-DATA_W];
            mb_d    = cur_byte[MB_BIT-DATA_W];
            addr_d  = cur_byte[ADDR_W-1:0];
            state_d = DATA;
            if (cur_byte[RW_BIT-DATA_W] == RW_READ) sh_out_d = rd_cmd;
          end
        end
      end
      DATA: begin
        if (sclk_fall && rw_q) begin
          miso_d   = sh_out_q[DATA_W-1];
          sh_out_d = {sh_out_q[DATA_W-2:0], 1'b0};
        end
        if (sclk_rise) begin
          sh_in_d = cur_byte[DATA_W-2:0];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 3'd7) begin
            if (rw_q != RW_READ) begin
              // Commit is staged one cycle so wr_valid lands a cycle later.
              pend_d      = 1'b1;
              pend_addr_d = addr_q;
              pend_data_d = cur_byte;
            end
            if (MULTI && mb_q) begin
              addr_d = addr_inc;
              if (rw_q == RW_READ) sh_out_d = rd_next;
            end else begin
              state_d = DONE;
              miso_d  = 1'b0;
            end
          end
        end
      end
      default: miso_d = 1'b0;
    endcase
    // cs release aborts from any state; an unfinished byte never reaches pend.
    if (cs_stop) begin
      state_d = IDLE;
      miso_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_in_q     <= '0;
      sh_out_q    <= '0;
      rw_q        <= 1'b0;
      mb_q        <= 1'b0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_in_q     <= sh_in_d;
      sh_out_q    <= sh_out_d;
      rw_q        <= rw_d;
      mb_q        <= mb_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  // Bank: the bus commit is written last so it overrides a same-address local write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      if (loc_we && in_range(loc_addr)) bank_q[loc_addr] <= loc_wdata;
      if (pend_q && in_range(pend_addr_q)) begin
        bank_q[pend_addr_q] <= pend_data_q;
        wr_valid_q          <= 1'b1;
        wr_addr_q           <= pend_addr_q;
        wr_data_q           <= pend_data_q;
      end
    end
  end

  assign spi_miso_oe = (state_q == DATA) && (rw_q == RW_READ);
  assign spi_miso    = miso_q & spi_miso_oe;
  assign busy        = (state_q != IDLE);
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
endmodule

// File: tb/tb_spi_slave_regs.sv
module tb_spi_slave_regs;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_clk = 1'b1, spi_cs = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, busy;
  logic       loc_we = 1'b0;
  logic [5:0] loc_addr = '0;
  logic [7:0] loc_wdata = '0;
  logic       wr_valid;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  int n_chk = 0, n_fail = 0;
  logic [13:0] wr_log [$];
  logic [23:0] rx, oe;
  int nb;
  bit got;

  spi_slave_regs #(.NUM_REGS(64), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .busy(busy),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_valid) wr_log.push_back({wr_addr, wr_data});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(posedge clk);
  endtask

  // Sends the low nbits of tx MSB first; captures miso and oe at each rise.
  task automatic frame(input logic [23:0] tx, input int nbits, input bit hold,
                       output logic [23:0] rxo, output logic [23:0] oeo);
    rxo = '0; oeo = '0;
    spi_cs = 1'b0;
    half();
    for (int i = 0; i < nbits; i++) begin
      spi_clk = 1'b0;
      spi_mosi = tx[nbits-1-i];
      half();
      spi_clk = 1'b1;
      rxo = {rxo[22:0], spi_miso};
      oeo = {oeo[22:0], spi_miso_oe};
      half();
    end
    if (!hold) begin
      spi_cs = 1'b1;
      half(); half();
    end
  endtask

  task automatic loc_write(input logic [5:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    loc_addr = a; loc_wdata = d; loc_we = 1'b1;
    @(posedge clk); #1;
    loc_we = 1'b0;
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    chk("rst_miso", spi_miso, 0);
    chk("rst_oe", spi_miso_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrv", wr_valid, 0);
    chk("rst_wra", wr_addr, 0);
    chk("rst_wrd", wr_data, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Bus write 0xAA to 0x38, then read it back.
    frame(24'h0038AA, 16, 1'b0, rx, oe);
    chk("wr1_cnt", wr_log.size(), 1);
    if (wr_log.size() > 0) begin
      chk("wr1_addr", wr_log[0][13:8], 6'h38);
      chk("wr1_data", wr_log[0][7:0], 8'hAA);
    end
    chk("wr1_busy", busy, 0);
    frame(24'h00B800, 16, 1'b0, rx, oe);
    chk("rd38", rx[7:0], 8'hAA);
    chk("rd38_oe", oe[15:0], 16'h00FF);
    chk("rd38_oe_after", spi_miso_oe, 0);

    // Local write then bus read; local writes never report.
    nb = wr_log.size();
    loc_write(6'h01, 8'h5C);
    frame(24'h008100, 16, 1'b0, rx, oe);
    chk("rd01", rx[7:0], 8'h5C);
    chk("rd01_oe", oe[15:0], 16'h00FF);
    chk("loc_no_wrv", wr_log.size(), nb);

    // Write 0x12 to 0x05 aborted after 11 bits.
    nb = wr_log.size();
    frame(24'h000512 >> 5, 11, 1'b0, rx, oe);
    chk("abort_no_wrv", wr_log.size(), nb);
    chk("abort_idle", busy, 0);
    frame(24'h008500, 16, 1'b0, rx, oe);
    chk("abort_rd05", rx[7:0], 8'h00);
    frame(24'h000577, 16, 1'b0, rx, oe);
    chk("next_wrv", wr_log.size(), nb + 1);
    frame(24'h008500, 16, 1'b0, rx, oe);
    chk("next_rd05", rx[7:0], 8'h77);

    // Local 0x33 held on 0x10 up to the bus commit of 0x44: bus wins.
    got = 1'b0;
    fork
      frame(24'h001044, 16, 1'b0, rx, oe);
      begin
        @(posedge clk); #1;
        loc_addr = 6'h10; loc_wdata = 8'h33; loc_we = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
          @(posedge clk); #1;
          if (wr_valid) got = 1'b1;
        end
        loc_we = 1'b0;
      end
    join
    chk("same_seen", got, 1);
    frame(24'h009000, 16, 1'b0, rx, oe);
    chk("same_rd10", rx[7:0], 8'h44);

    // Reset in the middle of a read of 0x38.
    frame(24'h00B800 >> 4, 12, 1'b1, rx, oe);
    chk("mid_oe_pre", spi_miso_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_miso", spi_miso, 0);
    chk("mid_oe", spi_miso_oe, 0);
    chk("mid_busy", busy, 0);
    chk("mid_wrv", wr_valid, 0);
    chk("mid_wra", wr_addr, 0);
    chk("mid_wrd", wr_data, 0);
    spi_cs = 1'b1; spi_clk = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    frame(24'h00B800, 16, 1'b0, rx, oe);
    chk("mid_rd38", rx[7:0], 8'h00);

    // MB write to 0x3F with bytes 0x01, 0x02.
    nb = wr_log.size();
    frame(24'h7F0102, 24, 1'b0, rx, oe);
`ifdef SPI_SLAVE_MULTIBYTE_EN
    chk("mb_cnt", wr_log.size(), nb + 2);
    if (wr_log.size() >= nb + 2) begin
      chk("mb_w0", wr_log[nb], {6'h3F, 8'h01});
      chk("mb_w1", wr_log[nb+1], {6'h00, 8'h02});
    end
`else
    chk("mb_cnt", wr_log.size(), nb + 1);
    if (wr_log.size() >= nb + 1) chk("mb_w0", wr_log[nb], {6'h3F, 8'h01});
    frame(24'h008000, 16, 1'b0, rx, oe);
    chk("mb_rd00", rx[7:0], 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
